iq_sample_merge: RTL and testbench
==================================

# iq_sample_merge

- Front end of the FM demodulator datapath.
- Assembles the free-running byte stream from the tuner interface into signed 16-bit I and Q samples.
- Presents each complete complex sample to the downstream I and Q FIR filters.
- Generates the filters' load strobe (`merge_finished_o`) and compute enable (`start_o`) sequence.

## Interface
- `OFFSET_BIN`, 0 — 1: incoming words are offset-binary; the MSB is inverted to give two's complement. 0: words pass unchanged.
- `START_CYCLES`, 2 — length of the `start_o` burst. Legal range is 1..3.
- `TIMEOUT`, 64 — idle cycles allowed inside a partial sample before realignment. Used only with `MERGE_TIMEOUT_EN`.
- `clk` in 1 — clock; all logic on the rising edge.
- `rst` in 1 — reset, asynchronous, active-high.
- `byte_valid_i` in 1 — `byte_i` is valid this cycle. At most one byte per cycle; there is no backpressure.
- `byte_i` in 8 — stream byte. Order per sample: I_lo, I_hi, Q_lo, Q_hi.
- `resync_i` in 1 — discard any partial sample and realign to I_lo.
- `clr_err_i` in 1 — clears sticky `err_o`.
- `i_o` out 16 — last complete I sample, signed.
- `q_o` out 16 — last complete Q sample, signed.
- `merge_finished_o` out 1 — one-cycle pulse: new `i_o`/`q_o` are valid. Filter buffer shift enable.
- `start_o` out 1 — filter compute enable burst.
- `err_o` out 1 — sticky realignment error.

## Operation
- FSM states: `S_I_LO` → `S_I_HI` → `S_Q_LO` → `S_Q_HI` → `S_I_LO`. The FSM advances only on cycles where `byte_valid_i`=1.
- Low bytes are held in internal 8-bit registers.
- On the `S_Q_HI` byte, in the same edge:
  - `i_o` = {I_hi, I_lo} and `q_o` = {byte_i, Q_lo}, with the MSB inverted when `OFFSET_BIN`=1.
  - `merge_finished_o` is set for exactly one cycle.
- Outputs hold their value between samples. `i_o`/`q_o` are never partially updated.
- `start_o` rises on the edge after `merge_finished_o` rises and stays high for `START_CYCLES` cycles.
  - With the default of 2, the filter registers its products, then its sum, from the freshly shifted buffer.
- `resync_i`=1: state returns to `S_I_LO` and held low bytes are discarded. `i_o`, `q_o` and any running `start_o` burst are unaffected.
- `resync_i` together with `byte_valid_i`: that byte is accepted as I_lo of a new sample (state → `S_I_HI`).
- `err_o` is set by a timeout realignment (see Configuration).
  - `clr_err_i`=1 clears it.
  - Set and clear in the same cycle: set wins.
- `resync_i` does not set `err_o`.

## Timing
- All outputs reset to 0; state resets to `S_I_LO`. Reset takes effect immediately and asynchronously, including mid-sample or mid-burst.
- Q_hi sampled at edge E:
  - `i_o`/`q_o` and `merge_finished_o`=1 from E.
  - `merge_finished_o`=0 from E+1.
  - `start_o`=1 from E+1 through E+`START_CYCLES`; low from E+1+`START_CYCLES`.
- Minimum spacing between completions is 4 cycles (4 bytes at 1 per cycle). `START_CYCLES`≤3 therefore guarantees bursts never overlap.
- If a new completion arrives while a burst is still running (only possible after `resync_i`), the burst counter restarts from the new completion.
- Latency from Q_hi accepted to `i_o`/`q_o` visible: 1 edge.

## Configuration
- `MERGE_TIMEOUT_EN` defined:
  - A counter clears on every accepted byte and increments each cycle while the state is not `S_I_LO` and `byte_valid_i`=0.
  - When the count reaches `TIMEOUT`: state → `S_I_LO`, partial bytes are discarded, `err_o` is set, and the counter clears.
  - In `S_I_LO` the counter is held at 0.
- `MERGE_TIMEOUT_EN` undefined:
  - No counter is built; a partial sample waits indefinitely.
  - `err_o` is constant 0 and `clr_err_i` is ignored.

## Test plan
- Basic sample: stream 0x34,0x12,0x78,0x56 on consecutive cycles → `i_o`=0x1234, `q_o`=0x5678, one-cycle `merge_finished_o`, `start_o` high exactly 2 cycles starting the next cycle.
- Offset binary (`OFFSET_BIN`=1): bytes 0x00,0x80,0xFF,0x7F → `i_o`=0x0000, `q_o`=0xFFFF.
- Gapped stream: bytes with 3 idle cycles between each → same values as the basic sample; exactly one `merge_finished_o` per 4 bytes.
- Resync: send 0xAA,0xBB, then `resync_i` together with 0x01, then 0x00,0x02,0x00 → `i_o`=0x0001, `q_o`=0x0002; `err_o` stays 0.
- Timeout (`MERGE_TIMEOUT_EN`, `TIMEOUT`=64): send 2 bytes then idle 64 cycles → `err_o`=1; the next 4 bytes form a correct sample; `clr_err_i` pulse → `err_o`=0.
- Reset mid-burst: assert `rst` asynchronously while `start_o`=1 → all outputs 0 immediately; after release, the first 4 bytes decode correctly.

Source files
------------

// File: rtl/iq_sample_merge.sv
// Byte-stream to complex-sample assembler feeding the I/Q FIR filters.
// Optional idle-timeout realignment is built when MERGE_TIMEOUT_EN is defined.
module iq_sample_merge #(
    parameter bit OFFSET_BIN   = 1'b0,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    input  logic        resync_i,
    input  logic        clr_err_i,
    output logic [15:0] i_o,
    output logic [15:0] q_o,
    output logic        merge_finished_o,
    output logic        start_o,
    output logic        err_o
);

    typedef enum logic [1:0] {S_I_LO, S_I_HI, S_Q_LO, S_Q_HI} state_t;

    localparam logic [15:0] MSB_FLIP = {OFFSET_BIN, 15'b0};

    state_t      state_q, state_d;
    logic [7:0]  i_lo_q, i_lo_d;
    logic [7:0]  i_hi_q, i_hi_d;
    logic [7:0]  q_lo_q, q_lo_d;
    logic [15:0] i_q, i_d;
    logic [15:0] q_q, q_d;
    logic        mf_q, mf_d;
    logic        start_q, start_d;
    logic [1:0]  burst_q, burst_d;
    state_t      cur;

`ifdef MERGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
`else
    logic unused_cfg;
    assign unused_cfg = clr_err_i ^ (TIMEOUT == 0);
`endif

    always_comb begin
        state_d = state_q;
        i_lo_d  = i_lo_q;
        i_hi_d  = i_hi_q;
        q_lo_d  = q_lo_q;
        i_d     = i_q;
        q_d     = q_q;
        mf_d    = 1'b0;
        start_d = 1'b0;
        burst_d = burst_q;
        cur     = resync_i ? S_I_LO : state_q;

        if (resync_i) begin
            state_d = S_I_LO;
            i_lo_d  = 8'h00;
            i_hi_d  = 8'h00;
            q_lo_d  = 8'h00;
        end

        if (byte_valid_i) begin
            case (cur)
                S_I_LO: begin i_lo_d = byte_i; state_d = S_I_HI; end
                S_I_HI: begin i_hi_d = byte_i; state_d = S_Q_LO; end
                S_Q_LO: begin q_lo_d = byte_i; state_d = S_Q_HI; end
                default: begin
                    // Both words land on the same edge so the filters never see a torn sample.
                    i_d     = {i_hi_q, i_lo_q} ^ MSB_FLIP;
                    q_d     = {byte_i, q_lo_q} ^ MSB_FLIP;
                    mf_d    = 1'b1;
                    state_d = S_I_LO;
                end
            endcase
        end

        // A fresh completion restarts the burst even if one is still running.
        if (mf_q) begin
            start_d = 1'b1;
            burst_d = 2'(START_CYCLES - 1);
        end else if (burst_q != 2'd0) begin
            start_d = 1'b1;
            burst_d = burst_q - 2'd1;
        end

`ifdef MERGE_TIMEOUT_EN
        tmo_d = tmo_q;
        err_d = err_q;
        if (clr_err_i)
            err_d = 1'b0;
        if (byte_valid_i || resync_i || state_q == S_I_LO) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            tmo_d   = '0;
            state_d = S_I_LO;
            i_lo_d  = 8'h00;
            i_hi_d  = 8'h00;
            q_lo_d  = 8'h00;
            err_d   = 1'b1;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_I_LO;
            i_lo_q  <= 8'h00;
            i_hi_q  <= 8'h00;
            q_lo_q  <= 8'h00;
            i_q     <= 16'h0000;
            q_q     <= 16'h0000;
            mf_q    <= 1'b0;
            start_q <= 1'b0;
            burst_q <= 2'd0;
`ifdef MERGE_TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            i_lo_q  <= i_lo_d;
            i_hi_q  <= i_hi_d;
            q_lo_q  <= q_lo_d;
            i_q     <= i_d;
            q_q     <= q_d;
            mf_q    <= mf_d;
            start_q <= start_d;
            burst_q <= burst_d;
`ifdef MERGE_TIMEOUT_EN
            tmo_q   <= tmo_d;
            err_q   <= err_d;
`endif
        end
    end

    assign i_o              = i_q;
    assign q_o              = q_q;
    assign merge_finished_o = mf_q;
    assign start_o          = start_q;
`ifdef MERGE_TIMEOUT_EN
    assign err_o            = err_q;
`else
    assign err_o            = 1'b0;
`endif

endmodule

// File: tb/tb_iq_sample_merge.sv
// Directed bench for iq_sample_merge: a plain-word instance and an offset-binary instance share stimulus.
module tb_iq_sample_merge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bv  = 1'b0;
    logic [7:0]  b   = 8'h00;
    logic        rs  = 1'b0;
    logic        clr = 1'b0;

    logic [15:0] i0, q0, i1, q1;
    logic        mf0, st0, er0, mf1, st1, er1;

    int errors = 0;
    int checks = 0;
    int mf_cnt = 0;
    int m0;

    iq_sample_merge #(.OFFSET_BIN(1'b0), .START_CYCLES(2), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .byte_valid_i(bv), .byte_i(b), .resync_i(rs), .clr_err_i(clr),
        .i_o(i0), .q_o(q0), .merge_finished_o(mf0), .start_o(st0), .err_o(er0)
    );

    iq_sample_merge #(.OFFSET_BIN(1'b1), .START_CYCLES(2), .TIMEOUT(64)) dut_ob (
        .clk(clk), .rst(rst), .byte_valid_i(bv), .byte_i(b), .resync_i(rs), .clr_err_i(clr),
        .i_o(i1), .q_o(q1), .merge_finished_o(mf1), .start_o(st1), .err_o(er1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mf0) mf_cnt <= mf_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] v, input logic r = 1'b0);
        bv = 1'b1; b = v; rs = r;
        @(negedge clk);
        bv = 1'b0; rs = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_i", 32'(i0), 32'h0);
        chk("rst_q", 32'(q0), 32'h0);
        chk("rst_mf", 32'(mf0), 32'h0);
        chk("rst_start", 32'(st0), 32'h0);
        chk("rst_err", 32'(er0), 32'h0);
        rst = 1'b0;
        idle(1);

        // Basic sample and burst shape
        send(8'h34); send(8'h12); send(8'h78); send(8'h56);
        chk("basic_i", 32'(i0), 32'h1234);
        chk("basic_q", 32'(q0), 32'h5678);
        chk("basic_mf_E", 32'(mf0), 32'h1);
        chk("basic_start_E", 32'(st0), 32'h0);
        idle(1);
        chk("basic_mf_E1", 32'(mf0), 32'h0);
        chk("basic_start_E1", 32'(st0), 32'h1);
        idle(1);
        chk("basic_start_E2", 32'(st0), 32'h1);
        idle(1);
        chk("basic_start_E3", 32'(st0), 32'h0);
        chk("basic_err", 32'(er0), 32'h0);

        // Offset binary
        send(8'h00); send(8'h80); send(8'hFF); send(8'h7F);
        chk("ob_i", 32'(i1), 32'h0000);
        chk("ob_q", 32'(q1), 32'hFFFF);
        chk("plain_i", 32'(i0), 32'h8000);
        chk("plain_q", 32'(q0), 32'h7FFF);
        idle(2);

        // Gapped stream
        m0 = mf_cnt;
        send(8'h34); idle(3);
        chk("gap_hold_i", 32'(i0), 32'h8000);
        send(8'h12); idle(3);
        send(8'h78); idle(3);
        chk("gap_no_mf", 32'(mf_cnt - m0), 32'd0);
        send(8'h56);
        chk("gap_i", 32'(i0), 32'h1234);
        chk("gap_q", 32'(q0), 32'h5678);
        chk("gap_mf", 32'(mf0), 32'h1);
        idle(4);
        chk("gap_mf_count", 32'(mf_cnt - m0), 32'd1);

        // Resync accompanied by a byte
        send(8'hAA); send(8'hBB);
        send(8'h01, 1'b1); send(8'h00); send(8'h02); send(8'h00);
        chk("rsync_i", 32'(i0), 32'h0001);
        chk("rsync_q", 32'(q0), 32'h0002);
        chk("rsync_err", 32'(er0), 32'h0);

        // Resync alone
        send(8'h11);
        rs = 1'b1; @(negedge clk); rs = 1'b0;
        chk("rsync2_hold_i", 32'(i0), 32'h0001);
        send(8'hCD); send(8'hAB); send(8'hEF); send(8'hBE);
        chk("rsync2_i", 32'(i0), 32'hABCD);
        chk("rsync2_q", 32'(q0), 32'hBEEF);
        idle(4);

`ifdef MERGE_TIMEOUT_EN
        send(8'h11); send(8'h22);
        idle(63);
        chk("tmo_err_63", 32'(er0), 32'h0);
        idle(1);
        chk("tmo_err_64", 32'(er0), 32'h1);
        send(8'h21); send(8'h43); send(8'h65); send(8'h87);
        chk("tmo_i", 32'(i0), 32'h4321);
        chk("tmo_q", 32'(q0), 32'h8765);
        chk("tmo_err_sticky", 32'(er0), 32'h1);
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        chk("tmo_err_clr", 32'(er0), 32'h0);
`else
        send(8'h11); send(8'h22);
        idle(100);
        chk("notmo_err", 32'(er0), 32'h0);
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        send(8'h33); send(8'h44);
        chk("notmo_i", 32'(i0), 32'h2211);
        chk("notmo_q", 32'(q0), 32'h4433);
`endif
        idle(4);

        // Asynchronous reset during the start burst
        send(8'h01); send(8'h80); send(8'h02); send(8'h40);
        chk("pre_rst_i", 32'(i0), 32'h8001);
        idle(1);
        chk("pre_rst_start", 32'(st0), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_i", 32'(i0), 32'h0);
        chk("arst_q", 32'(q0), 32'h0);
        chk("arst_start", 32'(st0), 32'h0);
        chk("arst_mf", 32'(mf0), 32'h0);
        chk("arst_err", 32'(er0), 32'h0);
        chk("arst_ob_i", 32'(i1), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        chk("post_rst_i", 32'(i0), 32'h5678);
        chk("post_rst_q", 32'(q0), 32'h1234);
        chk("post_rst_mf", 32'(mf0), 32'h1);
        chk("post_rst_ob_i", 32'(i1), 32'hD678);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
